jogo_rodadas_unidade_controle: RTL and testbench
================================================

// Module: jogo_rodadas_unidade_controle
// PURPOSE
//  Control unit for the multi-round sequence-memory game. Round k requires the player to repeat
//  memory entries 0..k. Adds round progression, a per-play timeout and a timeout end state.
//  Drives the datapath's address counter (E), round-limit counter (L) and play register (R).
//  Receives compare/end flags and the one-cycle jogada_feita pulse from the datapath.
//  The datapath compares the play against memory[E] and raises fimE when E == L.
// PARAMETERS
//  TIMEOUT_CYCLES  5000  cycles allowed in espera before timeout; legal range 2..2**TIMER_W-1
//  TIMER_W         13    width of the internal timeout counter
// PORTS
//  clock       in   1        system clock, rising edge
//  reset_n     in   1        asynchronous reset, active-low
//  iniciar     in   1        start/restart request, level-sampled
//  jogada      in   1        one-cycle pulse: player made a play
//  igual       in   1        play register equals memory[E]
//  fimE        in   1        address counter E equals round limit L
//  fimL        in   1        round limit L equals last round
//  zeraE       out  1        clear address counter E
//  contaE      out  1        increment address counter E
//  zeraL       out  1        clear round-limit counter L
//  contaL      out  1        increment round-limit counter L
//  zeraR       out  1        clear play register
//  registraR   out  1        load play register
//  acertou     out  1        game won (level)
//  errou       out  1        wrong play (level)
//  timeout     out  1        play not made in time (level)
//  pronto      out  1        game over, any end state
//  db_estado   out  4        current state code
//  db_timer    out  TIMER_W  timeout counter value
// BEHAVIOUR
//  Reset (reset_n = 0, asynchronous): state = inicial, timer = 0, all outputs 0, db_estado = 0000.
//  Outputs are Moore, decoded only from the current state.
//  States, codes and transitions:
//   inicial         0000  iniciar -> preparacao; else stay
//   preparacao      0001  zeraE=zeraL=zeraR=1; -> espera
//   espera          0011  if jogada -> registra; elif timer==TIMEOUT_CYCLES-1 -> final_timeout; else stay
//   registra        0100  registraR=1; -> comparacao
//   comparacao      0101  !igual -> final_erro; igual&fimE&fimL -> final_acerto;
//                         igual&fimE&!fimL -> proxima_rodada; igual&!fimE -> proxima_jogada
//   proxima_jogada  0110  contaE=1; -> espera
//   proxima_rodada  0111  contaL=1, zeraE=1; -> espera
//   final_acerto    1000  acertou=1, pronto=1; iniciar -> preparacao
//   final_erro      1001  errou=1, pronto=1; iniciar -> preparacao
//   final_timeout   1010  timeout=1, pronto=1; iniciar -> preparacao
//   unused codes          -> inicial next cycle; all outputs 0
//  Timer:
//   - 0 in every state other than espera; increments by 1 each cycle spent in espera.
//   - Never wraps: the timeout check fires at TIMEOUT_CYCLES-1.
//   - Each re-entry to espera restarts the count from 0, so every play gets a full window.
//  Simultaneous events:
//   - jogada in the same cycle the timer hits the limit -> registra (the play wins).
//   - iniciar is ignored in every state except inicial and the three final states.
//  Latency:
//   - Accepted jogada to acertou/errou/proxima_*: 2 cycles (registra, comparacao).
//   - Timeout fires exactly TIMEOUT_CYCLES cycles after entry into espera if no jogada arrives.
//  Reset mid-game returns to inicial immediately; the datapath counters are not cleared until preparacao.
// TESTING (bench uses TIMEOUT_CYCLES=8)
//  1 Reset, iniciar 1 cycle, 3 rounds (fimL high in round 2), all igual=1 -> acertou=1, pronto=1,
//    contaL pulsed 2x, contaE pulsed 0+1+2=3x.
//  2 Round 1, second play igual=0 -> errou=1, pronto=1, db_estado=1001, acertou=0, timeout=0.
//  3 No jogada after preparacao -> timeout=1 exactly 8 cycles after entering espera; db_estado=1010.
//  4 jogada on the same cycle timer==7 -> registra taken, no timeout; timer reads 0 afterwards.
//  5 From final_erro, iniciar=1 -> preparacao with zeraE=zeraL=zeraR=1 for 1 cycle; new game plays
//    normally to acertou.
//  6 reset_n pulsed low during comparacao, mid-cycle -> outputs 0 and db_estado=0000 asynchronously;
//    iniciar ignored in registra and espera.

Source files
------------

// File: rtl/jogo_rodadas_unidade_controle.sv
// Control FSM for the multi-round sequence-memory game: round progression, per-play
// timeout and the three end states. Outputs are registered Moore decodes of the state.
module jogo_rodadas_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TIMER_W        = 13
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               iniciar,
    input  logic               jogada,
    input  logic               igual,
    input  logic               fimE,
    input  logic               fimL,
    output logic               zeraE,
    output logic               contaE,
    output logic               zeraL,
    output logic               contaL,
    output logic               zeraR,
    output logic               registraR,
    output logic               acertou,
    output logic               errou,
    output logic               timeout,
    output logic               pronto,
    output logic [3:0]         db_estado,
    output logic [TIMER_W-1:0] db_timer
);

    typedef enum logic [3:0] {
        INICIAL        = 4'b0000,
        PREPARACAO     = 4'b0001,
        ESPERA         = 4'b0011,
        REGISTRA       = 4'b0100,
        COMPARACAO     = 4'b0101,
        PROXIMA_JOGADA = 4'b0110,
        PROXIMA_RODADA = 4'b0111,
        FINAL_ACERTO   = 4'b1000,
        FINAL_ERRO     = 4'b1001,
        FINAL_TIMEOUT  = 4'b1010
    } t_estado;

    localparam logic [TIMER_W-1:0] LP_TIMER_LIM = TIMER_W'(TIMEOUT_CYCLES - 1);

    t_estado              r_estado;
    logic [TIMER_W-1:0]   r_timer;
    logic [9:0]           r_saidas;
    t_estado              w_prox;
    logic                 w_lim;

    // A play arriving on the limit cycle still wins over the timeout.
    function automatic t_estado f_proximo(input t_estado e, input logic ini, input logic jog,
                                          input logic ig, input logic fe, input logic fl,
                                          input logic lim);
        t_estado p;
        case (e)
            INICIAL:        p = ini ? PREPARACAO : INICIAL;
            PREPARACAO:     p = ESPERA;
            ESPERA:         p = jog ? REGISTRA : (lim ? FINAL_TIMEOUT : ESPERA);
            REGISTRA:       p = COMPARACAO;
            COMPARACAO: begin
                if (!ig)      p = FINAL_ERRO;
                else if (!fe) p = PROXIMA_JOGADA;
                else if (fl)  p = FINAL_ACERTO;
                else          p = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: p = ESPERA;
            PROXIMA_RODADA: p = ESPERA;
            FINAL_ACERTO,
            FINAL_ERRO,
            FINAL_TIMEOUT:  p = ini ? PREPARACAO : e;
            default:        p = INICIAL;
        endcase
        return p;
    endfunction

    // Packing: {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto}
    function automatic logic [9:0] f_saidas(input t_estado e);
        logic [9:0] s;
        case (e)
            PREPARACAO:     s = 10'b10_10_10_0000;
            REGISTRA:       s = 10'b00_00_01_0000;
            PROXIMA_JOGADA: s = 10'b01_00_00_0000;
            PROXIMA_RODADA: s = 10'b10_01_00_0000;
            FINAL_ACERTO:   s = 10'b00_00_00_1001;
            FINAL_ERRO:     s = 10'b00_00_00_0101;
            FINAL_TIMEOUT:  s = 10'b00_00_00_0011;
            default:        s = 10'b00_00_00_0000;
        endcase
        return s;
    endfunction

    always_comb begin
        w_lim  = (r_timer == LP_TIMER_LIM);
        w_prox = f_proximo(r_estado, iniciar, jogada, igual, fimE, fimL, w_lim);
    end

    // Timer restarts on every entry to espera, so each play gets the full window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= INICIAL;
            r_timer  <= '0;
            r_saidas <= '0;
        end else begin
            r_estado <= w_prox;
            r_saidas <= f_saidas(w_prox);
            if (r_estado == ESPERA && w_prox == ESPERA)
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;
        end
    end

    assign {zeraE, contaE, zeraL, contaL, zeraR, registraR,
            acertou, errou, timeout, pronto} = r_saidas;
    assign db_estado = r_estado;
    assign db_timer  = r_timer;

endmodule

// File: tb/tb_jogo_rodadas_unidade_controle.sv
// Bench for the game control unit: a behavioural datapath (E/L counters) plus a
// game-level model of rounds and plays that predicts each outcome.
module tb_jogo_rodadas_unidade_controle;

    localparam int TO = 8;
    localparam int TW = 13;

    localparam logic [3:0] S_INI = 4'b0000, S_PREP = 4'b0001, S_ESP = 4'b0011,
                           S_REG = 4'b0100, S_CMP = 4'b0101, S_PJ = 4'b0110,
                           S_PR = 4'b0111, S_ACE = 4'b1000, S_ERR = 4'b1001,
                           S_TO = 4'b1010;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          iniciar = 1'b0;
    logic          jogada = 1'b0;
    logic          igual = 1'b0;
    logic          fimE, fimL;
    logic          zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic          acertou, errou, timeout, pronto;
    logic [3:0]    db_estado;
    logic [TW-1:0] db_timer;
    logic [9:0]    outs;
    logic [3:0]    fim_flags;

    int n_tests = 0;
    int n_fail  = 0;

    int E = 0, L = 0, last_round = 0;
    int nContaE = 0, nContaL = 0;

    jogo_rodadas_unidade_controle #(.TIMEOUT_CYCLES(TO), .TIMER_W(TW)) dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimL(fimL),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
        .timeout(timeout), .pronto(pronto), .db_estado(db_estado), .db_timer(db_timer)
    );

    always #5 clock = ~clock;

    // Behavioural datapath: address counter E and round-limit counter L
    always @(posedge clock) begin
        if (zeraE) E <= 0; else if (contaE) E <= E + 1;
        if (zeraL) L <= 0; else if (contaL) L <= L + 1;
        if (contaE) nContaE <= nContaE + 1;
        if (contaL) nContaL <= nContaL + 1;
    end
    assign fimE = (E == L);
    assign fimL = (L == last_round);
    assign outs = {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto};
    assign fim_flags = {acertou, errou, timeout, pronto};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("prep_state", db_estado, S_PREP);
        chk("prep_zeros", {zeraE, zeraL, zeraR, contaE, contaL}, 5'b11100);
        @(negedge clock);
        chk("prep_one_cycle", {zeraE, zeraL, zeraR}, 3'b000);
    endtask

    // Starts in espera with the timer at 0, ends at the comparacao cycle.
    task automatic do_play(input int d, input bit ok, input bit noise);
        chk("espera_state", db_estado, S_ESP);
        chk("espera_timer0", db_timer, 0);
        if (noise) iniciar = 1'b1;
        for (int j = 1; j <= d; j++) begin
            @(negedge clock);
            chk("espera_hold", db_estado, S_ESP);
            chk("timer_count", db_timer, j);
        end
        jogada = 1'b1;
        igual  = ok;
        @(negedge clock);
        jogada = 1'b0;
        chk("registra_state", db_estado, S_REG);
        chk("registraR", registraR, 1'b1);
        chk("timer_cleared", db_timer, 0);
        @(negedge clock);
        iniciar = 1'b0;
        chk("comparacao_state", db_estado, S_CMP);
    endtask

    task automatic timeout_seq();
        chk("to_espera_state", db_estado, S_ESP);
        for (int j = 1; j < TO; j++) begin
            @(negedge clock);
            chk("to_timer_count", db_timer, j);
            chk("to_still_espera", db_estado, S_ESP);
        end
        @(negedge clock);
        chk("to_state", db_estado, S_TO);
        chk("to_timer_zero", db_timer, 0);
    endtask

    // mode 0: all plays right; 1: wrong play at (fk,fi); 2: no play at (fk,fi)
    task automatic run_game(input int last, input int mode, input int fk, input int fi,
                            input bit fixed_d, input bit noise);
        int expE, expL, baseE, baseL, d;
        logic [3:0] expS;
        bit done, ok;
        expE = 0; expL = 0; done = 0; expS = S_INI;
        last_round = last;
        baseE = nContaE; baseL = nContaL;
        start_game();
        for (int k = 0; k <= last; k++) begin
            for (int i = 0; i <= k; i++) begin
                if (!done) begin
                    if (mode == 2 && k == fk && i == fi) begin
                        timeout_seq();
                        expS = S_TO;
                        done = 1;
                    end else begin
                        d  = fixed_d ? ((i == k) ? TO - 1 : i) : int'($urandom_range(0, TO - 1));
                        ok = !(mode == 1 && k == fk && i == fi);
                        do_play(d, ok, noise);
                        @(negedge clock);
                        if (!ok) begin expS = S_ERR; done = 1; end
                        else if (i < k) begin expS = S_PJ; expE++; end
                        else if (k < last) begin expS = S_PR; expL++; end
                        else begin expS = S_ACE; done = 1; end
                        chk("outcome_state", db_estado, expS);
                        if (expS == S_PJ) chk("contaE_pulse", {contaE, zeraE}, 2'b10);
                        if (expS == S_PR) chk("contaL_zeraE", {contaL, zeraE, contaE}, 3'b110);
                        if (!done) @(negedge clock);
                    end
                end
            end
        end
        case (expS)
            S_ACE:   chk("end_flags_acerto", fim_flags, 4'b1001);
            S_ERR:   chk("end_flags_erro", fim_flags, 4'b0101);
            default: chk("end_flags_timeout", fim_flags, 4'b0011);
        endcase
        chk("contaE_total", nContaE - baseE, expE);
        chk("contaL_total", nContaL - baseL, expL);
        @(negedge clock);
        chk("end_state_holds", db_estado, expS);
    endtask

    initial begin
        int lst, md, fk, fi;
        repeat (2) @(negedge clock);
        chk("reset_state", db_estado, S_INI);
        chk("reset_outs", outs, 10'd0);
        chk("reset_timer", db_timer, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_state", db_estado, S_INI);

        // three rounds, all right, last play of each round on the timer limit
        run_game(2, 0, 0, 0, 1'b1, 1'b0);
        // wrong second play of round 1, then restart from final_erro
        run_game(2, 1, 1, 1, 1'b0, 1'b0);
        run_game(2, 0, 0, 0, 1'b0, 1'b1);
        // timeout on first play, and on a later play
        run_game(2, 2, 0, 0, 1'b0, 1'b0);
        run_game(3, 2, 2, 1, 1'b0, 1'b0);

        for (int g = 0; g < 6; g++) begin
            lst = int'($urandom_range(0, 3));
            md  = int'($urandom_range(0, 2));
            fk  = int'($urandom_range(0, lst));
            fi  = int'($urandom_range(0, fk));
            run_game(lst, md, fk, fi, 1'b0, g[0]);
        end

        // asynchronous reset in the middle of comparacao
        last_round = 2;
        start_game();
        do_play(0, 1'b1, 1'b0);
        @(negedge clock);
        chk("pre_reset_rodada", db_estado, S_PR);
        @(negedge clock);
        do_play(2, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_state", db_estado, S_INI);
        chk("async_reset_outs", outs, 10'd0);
        chk("async_reset_timer", db_timer, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", db_estado, S_INI);
        run_game(1, 0, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
